// File: rtl/wb_serializer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_serializer_fifo: Wishbone TX FIFO feeding a framed, LSB-first serial  |
// | line (start, payload+k, optional even parity, stop).  Rev 1.0            |
// +--------------------------------------------------------------------------+
module wb_serializer_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int CLKDIV    = 4,
  parameter int PARITY_EN = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] DAT_O,
  output logic        serial_o,
  output logic        ena_o,
  output logic        eot_o,
  output logic        irq_o
);

  localparam int SYM_W = DATA_W + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(SYM_W);
  localparam int DVW   = $clog2(CLKDIV);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DVW-1:0]     div_q, div_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [SYM_W-1:0]   sym_q, sym_d;

  logic [SYM_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        count_q;
  logic               enable_q, irq_en_q, ovf_q, irq_q;
  logic [15:0]        kcount_q;

  logic        w_req, w_full, w_empty, w_wr_tx, w_wr_ctrl;
  logic        w_push, w_pop, w_err, w_flush, w_clr_ovf, w_tick, w_eot;
  logic [1:0]  w_adr;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Reset also silences the combinational bus outputs.
  assign w_req     = CYC_I & STB_I & ~RST_I;
  assign w_adr     = ADR_I[3:2];
  assign w_full    = (count_q == (AW+1)'(DEPTH));
  assign w_empty   = (count_q == '0);
  assign w_wr_tx   = w_req & WE_I & (w_adr == 2'd0);
  assign w_wr_ctrl = w_req & WE_I & (w_adr == 2'd2);
  assign w_err     = w_wr_tx & w_full;
  assign w_push    = w_wr_tx & ~w_full;
  assign w_flush   = w_wr_ctrl & DAT_I[1];
  assign w_clr_ovf = w_wr_ctrl & DAT_I[2];
  assign w_tick    = (div_q == DVW'(CLKDIV - 1));
  assign w_unused  = ^{ADR_I[31:4], ADR_I[1:0], DAT_I[31:SYM_W]};

  assign ACK_O = w_req & ~w_err;
  assign ERR_O = w_err;

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      2'd1: begin
        w_rdata[0]    = (state_q != S_IDLE);
        w_rdata[1]    = w_full;
        w_rdata[2]    = w_empty;
        w_rdata[15:8] = 8'(count_q);
        w_rdata[16]   = ovf_q;
      end
      2'd2: begin
        w_rdata[0] = enable_q;
        w_rdata[3] = irq_en_q;
      end
      2'd3:    w_rdata[15:0] = kcount_q;
      default: w_rdata = '0;
    endcase
  end

  assign DAT_O = (w_req & ~WE_I) ? w_rdata : '0;

  always_ff @(posedge CLK_I) begin
    if (w_push) mem_q[wptr_q] <= DAT_I[SYM_W-1:0];
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (w_flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + AW'(1);
      if (w_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      kcount_q <= '0;
    end else begin
      if (w_wr_ctrl) begin
        enable_q <= DAT_I[0];
        irq_en_q <= DAT_I[3];
      end
      if (w_err)          ovf_q <= 1'b1;
      else if (w_clr_ovf) ovf_q <= 1'b0;
      irq_q <= irq_en_q & w_empty & (state_q == S_IDLE);
      if (w_eot & sym_q[SYM_W-1]) kcount_q <= kcount_q + 16'd1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sym_q   <= sym_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sym_d   = sym_q;
    w_pop   = 1'b0;
    w_eot   = 1'b0;
    if (state_q == S_IDLE) begin
      // A flush in this cycle wins over starting a new frame.
      if (enable_q & ~w_empty & ~w_flush) begin
        w_pop   = 1'b1;
        sym_d   = mem_q[rptr_q];
        div_d   = '0;
        state_d = S_START;
      end
    end else begin
      div_d = w_tick ? '0 : div_q + DVW'(1);
      case (state_q)
        S_START: if (w_tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
        S_DATA: if (w_tick) begin
          if (bit_q == BW'(SYM_W - 1))
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else
            bit_d = bit_q + BW'(1);
        end
        S_PARITY: if (w_tick) state_d = S_STOP;
        S_STOP: if (w_tick) begin
          w_eot   = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    serial_o = 1'b0;
    case (state_q)
      S_START:  serial_o = 1'b1;
      S_DATA:   serial_o = sym_q[bit_q];
      S_PARITY: serial_o = ^sym_q;
      default:  serial_o = 1'b0;
    endcase
  end

  assign ena_o = (state_q != S_IDLE);
  assign eot_o = w_eot;
  assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_serializer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_serializer_fifo: directed bench with a queue-based reference model |
// | for wb_serializer_fifo.  Rev 1.0                                         |
// +--------------------------------------------------------------------------+
module tb_wb_serializer_fifo;

  localparam int SW    = 9;
  localparam int CD    = 4;
  localparam int PE    = 1;
  localparam int DEPTH = 16;
  localparam int FL    = (2 + SW + PE) * CD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack, err, ser, ena, eot, irq;
  logic [31:0] rdat;

  logic        cyc2 = 1'b0, stb2 = 1'b0, we2 = 1'b0;
  logic [31:0] adr2 = '0, dat2 = '0;
  logic        ack2, err2, ser2, ena2, eot2, irq2;
  logic [31:0] rdat2;

  wb_serializer_fifo dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(dat), .ACK_O(ack), .ERR_O(err), .DAT_O(rdat),
    .serial_o(ser), .ena_o(ena), .eot_o(eot), .irq_o(irq)
  );

  wb_serializer_fifo #(.DATA_W(8), .DEPTH(16), .CLKDIV(2), .PARITY_EN(0)) dut2 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc2), .STB_I(stb2), .WE_I(we2),
    .ADR_I(adr2), .DAT_I(dat2), .ACK_O(ack2), .ERR_O(err2), .DAT_O(rdat2),
    .serial_o(ser2), .ena_o(ena2), .eot_o(eot2), .irq_o(irq2)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
  endtask

  // Reference model: symbol queue plus the position inside the current frame.
  logic [8:0]  mq[$];
  logic [8:0]  m_cur;
  bit          m_en, m_ie, m_ovf, m_act, m_irq;
  int          m_pos;
  logic [15:0] m_k;
  bit          m_req, m_fl, m_irq_n;
  int          m_sz;
  logic        e_ser, e_eot, e_ack, e_err;
  logic [31:0] e_rd;

  function automatic logic fbit(input logic [8:0] s, input int i);
    if (i == 0) return 1'b1;
    if (i <= SW) return s[i-1];
    if (PE != 0 && i == SW + 1) return ^s;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst serial_o", 32'(ser), 0);
      chk("rst ena_o", 32'(ena), 0);
      chk("rst eot_o", 32'(eot), 0);
      chk("rst irq_o", 32'(irq), 0);
      chk("rst ACK_O", 32'(ack), 0);
      chk("rst DAT_O", rdat, 0);
      mq.delete();
      m_en = 0; m_ie = 0; m_ovf = 0; m_act = 0; m_irq = 0; m_pos = 0; m_k = '0; m_cur = '0;
    end else begin
      m_req = cyc && stb;
      m_sz  = mq.size();
      e_ser = m_act ? fbit(m_cur, m_pos / CD) : 1'b0;
      e_eot = m_act && (m_pos == FL - 1);
      e_err = m_req && we && adr[3:2] == 2'd0 && m_sz == DEPTH;
      e_ack = m_req && !e_err;
      e_rd  = '0;
      if (m_req && !we) begin
        case (adr[3:2])
          2'd1: e_rd = {15'd0, m_ovf, 8'(m_sz), 5'd0, m_sz == 0, m_sz == DEPTH, m_act};
          2'd2: e_rd = {28'd0, m_ie, 2'b00, m_en};
          2'd3: e_rd = {16'd0, m_k};
          default: e_rd = '0;
        endcase
      end
      chk("serial_o", 32'(ser), 32'(e_ser));
      chk("ena_o", 32'(ena), 32'(m_act));
      chk("eot_o", 32'(eot), 32'(e_eot));
      chk("irq_o", 32'(irq), 32'(m_irq));
      chk("ACK_O", 32'(ack), 32'(e_ack));
      chk("ERR_O", 32'(err), 32'(e_err));
      chk("DAT_O", rdat, e_rd);

      // Advance the model to the state after the coming clock edge.
      m_irq_n = m_ie && m_sz == 0 && !m_act;
      m_fl    = m_req && we && adr[3:2] == 2'd2 && dat[1];
      if (m_act) begin
        if (m_pos == FL - 1) begin
          m_act = 0;
          if (m_cur[8]) m_k++;
        end else m_pos++;
      end else if (m_en && m_sz > 0 && !m_fl) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_pos = 0;
      end
      if (m_req && we) begin
        if (adr[3:2] == 2'd0) begin
          if (m_sz == DEPTH) m_ovf = 1;
          else mq.push_back(dat[8:0]);
        end else if (adr[3:2] == 2'd2) begin
          m_en = dat[0];
          m_ie = dat[3];
          if (dat[2]) m_ovf = 0;
          if (dat[1]) mq.delete();
        end
      end
      m_irq = m_irq_n;
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic ena_p = 1'b0;
  int   starts[$];
  always @(negedge clk) begin
    if (ena && !ena_p) starts.push_back(cyc_n);
    ena_p = ena;
  end

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic k, output logic e, output logic [31:0] r);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = {28'd0, a, 2'b00}; dat = d;
    @(negedge clk);
    k = ack; e = err; r = rdat;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wait_eot();
    bit hit = 0;
    int n = 0;
    while (!hit && n < 300) begin
      @(negedge clk);
      n++;
      hit = (eot === 1'b1);
    end
    chk("eot seen", 32'(hit), 1);
  endtask

  task automatic wait_rise_ena();
    bit   hit = 0;
    logic p = ena;
    int   n = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      hit = (ena === 1'b1) && !p;
      p = ena;
    end
    chk("ena rise", 32'(hit), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  int          exp1[12] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
  int          exp2[11] = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
  logic        bk, be;
  logic [31:0] br;
  int          eot_at, n2;
  bit          hit2;

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    bus(0, 2'd1, 0, bk, be, br);
    chk("status after reset", br, 32'h4);

    // Single plain symbol, full bit pattern and frame length.
    bus(1, 2'd2, 32'h1, bk, be, br);
    bus(1, 2'd0, 32'h0A5, bk, be, br);
    wait_rise_ena();
    eot_at = 0;
    for (int i = 0; i < 48; i++) begin
      if (i % 4 == 0) chk("t1 bit", 32'(ser), exp1[i/4]);
      if (eot) eot_at = i + 1;
      if (i != 47) @(negedge clk);
    end
    chk("t1 eot cycle", eot_at, 48);
    repeat (2) @(negedge clk);
    bus(0, 2'd3, 0, bk, be, br);
    chk("t1 kcount", br, 0);

    // Back-to-back K-code and data symbol.
    starts.delete();
    bus(1, 2'd0, 32'h1BC, bk, be, br);
    bus(1, 2'd0, 32'h055, bk, be, br);
    wait_eot();
    wait_eot();
    chk("t2 frames", starts.size(), 2);
    chk("t2 start spacing", starts[1] - starts[0], 49);
    repeat (2) @(negedge clk);
    bus(0, 2'd3, 0, bk, be, br);
    chk("t2 kcount", br, 1);

    // Fill to full, overflow, clear overflow.
    bus(1, 2'd2, 32'h0, bk, be, br);
    for (int i = 0; i < 16; i++) bus(1, 2'd0, 32'(i + 1), bk, be, br);
    bus(0, 2'd1, 0, bk, be, br);
    chk("t3 status full", br, 32'h1002);
    bus(1, 2'd0, 32'h0FF, bk, be, br);
    chk("t3 overflow ACK_O", 32'(bk), 0);
    chk("t3 overflow ERR_O", 32'(be), 1);
    bus(0, 2'd1, 0, bk, be, br);
    chk("t3 status ovf", br, 32'h11002);
    bus(1, 2'd2, 32'h4, bk, be, br);
    bus(0, 2'd1, 0, bk, be, br);
    chk("t3 status ovf cleared", br, 32'h1002);

    // Flush during the second frame, then idle interrupt.
    bus(1, 2'd2, 32'h2, bk, be, br);
    bus(0, 2'd1, 0, bk, be, br);
    chk("t4 status flushed", br, 32'h4);
    bus(1, 2'd0, 32'h011, bk, be, br);
    bus(1, 2'd0, 32'h022, bk, be, br);
    bus(1, 2'd0, 32'h033, bk, be, br);
    bus(1, 2'd0, 32'h044, bk, be, br);
    starts.delete();
    bus(1, 2'd2, 32'h9, bk, be, br);
    wait_eot();
    repeat (10) @(negedge clk);
    bus(1, 2'd2, 32'hB, bk, be, br);
    wait_eot();
    @(negedge clk);
    chk("t4 irq lag", 32'(irq), 0);
    @(negedge clk);
    chk("t4 irq", 32'(irq), 1);
    repeat (60) @(negedge clk);
    chk("t4 frames", starts.size(), 2);
    bus(0, 2'd1, 0, bk, be, br);
    chk("t4 status empty", br, 32'h4);

    // Reset in the middle of the data bits.
    bus(1, 2'd0, 32'h1FF, bk, be, br);
    bus(1, 2'd0, 32'h0F0, bk, be, br);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    chk("t5 serial before reset", 32'(ser), 1);
    cyc = 1; stb = 1; we = 0; adr = 32'h4;
    #1 rst = 1;
    #1;
    chk("t5 serial_o", 32'(ser), 0);
    chk("t5 ena_o", 32'(ena), 0);
    chk("t5 ACK_O", 32'(ack), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 0; cyc = 0; stb = 0;
    bus(0, 2'd1, 0, bk, be, br);
    chk("t5 status", br, 32'h4);
    bus(0, 2'd3, 0, bk, be, br);
    chk("t5 kcount", br, 0);

    // CLKDIV=2, no parity: 11 bits of 2 cycles.
    @(posedge clk); #1;
    cyc2 = 1; stb2 = 1; we2 = 1; adr2 = 32'h8; dat2 = 32'h1;
    @(posedge clk); #1;
    adr2 = 32'h0; dat2 = 32'h0A4;
    @(posedge clk); #1;
    cyc2 = 0; stb2 = 0; we2 = 0;
    hit2 = 0;
    n2 = 0;
    while (!hit2 && n2 < 20) begin
      @(negedge clk);
      n2++;
      hit2 = (ena2 === 1'b1);
    end
    chk("t6 start", 32'(hit2), 1);
    n2 = 0;
    eot_at = 0;
    while (ena2 === 1'b1 && n2 < 100) begin
      if (n2 % 2 == 0 && n2 / 2 < 11) chk("t6 bit", 32'(ser2), exp2[n2/2]);
      if (eot2) eot_at = n2 + 1;
      n2++;
      @(negedge clk);
    end
    chk("t6 frame length", n2, 22);
    chk("t6 eot cycle", eot_at, 22);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
